// File: rtl/game_2048_pkg.sv
// Shared definitions for the 2048 front end: direction codes, conditioner
// FSM states, default debounce timing and the move priority pick.
package game_2048_pkg;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_L = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_WIDTH_DEF       = 19;
  localparam int SYNC_STAGES_DEF     = 2;

  // Request vector bit order matches the direction code: [0]=R [1]=L [2]=U [3]=D.
  function automatic dir_e pick_dir(input logic [3:0] req);
    if (req[0])      return DIR_R;
    else if (req[1]) return DIR_L;
    else if (req[2]) return DIR_U;
    else if (req[3]) return DIR_D;
    else             return DIR_R;
  endfunction

  function automatic logic [3:0] dir_onehot(input dir_e dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One push-button: metastability synchronizer followed by a stable-level
// debouncer; reports the accepted level and a one-cycle rise strobe.
module debounce_bit
  import game_2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   stable_prev_q;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_bit != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_bit;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q        <= '0;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_q & ~stable_prev_q;

endmodule

// File: rtl/move_input_conditioner.sv
// Turns four bouncy push-buttons into single-cycle move pulses for logic_2048:
// one move per press, one direction at a time, nothing while inhibited.
//   state   | meaning
//   ST_IDLE | all buttons released, next accepted press may emit a move
//   ST_LOCK | a press was taken (or dropped); wait for every button to release
module move_input_conditioner
  import game_2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_l,
  input  logic       raw_r,
  input  logic       raw_u,
  input  logic       raw_d,
  input  logic       inhibit,
  output logic       btnL,
  output logic       btnR,
  output logic       btnU,
  output logic       btnD,
  output logic       locked,
  output logic [1:0] dir_last
);

  logic [3:0] raw_w;
  logic [3:0] stable_w;
  logic [3:0] press_w;

  state_e     state_q;
  logic [3:0] btn_q;
  logic       locked_q;
  dir_e       dir_q;

  assign raw_w = {raw_d, raw_u, raw_l, raw_r};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (raw_w[i]),
      .stable_o(stable_w[i]),
      .rise_o  (press_w[i])
    );
  end

  // IDLE is only ever left on the cycle the first level goes high, so the
  // rise strobes there carry exactly the buttons that are down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      btn_q    <= '0;
      locked_q <= 1'b0;
      dir_q    <= DIR_R;
    end else begin
      btn_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|stable_w) begin
            state_q  <= ST_LOCK;
            locked_q <= 1'b1;
            if (!inhibit) begin
              btn_q <= dir_onehot(pick_dir(press_w));
              dir_q <= pick_dir(press_w);
            end
          end
        end
        ST_LOCK: begin
          if (~|stable_w) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign btnR     = btn_q[0];
  assign btnL     = btn_q[1];
  assign btnU     = btn_q[2];
  assign btnD     = btn_q[3];
  assign locked   = locked_q;
  assign dir_last = dir_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with a short debounce window.
module tb_move_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       raw_l, raw_r, raw_u, raw_d;
  logic       inhibit;
  logic       btnL, btnR, btnU, btnD;
  logic       locked;
  logic [1:0] dir_last;

  int checks = 0;
  int errors = 0;
  int p_r = 0, p_l = 0, p_u = 0, p_d = 0;
  logic prev_any = 1'b0;
  logic locked_seen = 1'b0;

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (3),
    .SYNC_STAGES    (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_l   (raw_l),
    .raw_r   (raw_r),
    .raw_u   (raw_u),
    .raw_d   (raw_d),
    .inhibit (inhibit),
    .btnL    (btnL),
    .btnR    (btnR),
    .btnU    (btnU),
    .btnD    (btnD),
    .locked  (locked),
    .dir_last(dir_last)
  );

  always #5 clk = ~clk;

  // Per-cycle pulse counting plus the one-hot and gap-after-pulse invariants.
  always @(negedge clk) begin
    logic any;
    any = btnL | btnR | btnU | btnD;
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones({btnL, btnR, btnU, btnD}) > 1 || (prev_any && any)) begin
        errors++;
        $display("FAIL pulse_shape: btn LRUD=%b%b%b%b prev_any=%b, required at most one and a low gap",
                 btnL, btnR, btnU, btnD, prev_any);
      end
    end
    if (btnR) p_r++;
    if (btnL) p_l++;
    if (btnU) p_u++;
    if (btnD) p_d++;
    if (locked) locked_seen = 1'b1;
    prev_any = any;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [3:0] v);
    raw_r = v[0];
    raw_l = v[1];
    raw_u = v[2];
    raw_d = v[3];
  endtask

  task automatic clear_counts();
    p_r = 0; p_l = 0; p_u = 0; p_d = 0;
    locked_seen = 1'b0;
  endtask

  task automatic release_all();
    int k;
    set_raw(4'b0000);
    inhibit = 1'b0;
    k = 0;
    while (locked !== 1'b0 && k < 50) begin
      wait_cyc(1);
      k++;
    end
    check("unlock_timeout", int'(locked), 0);
    wait_cyc(4);
  endtask

  typedef struct {
    logic [3:0] raw;   // [0]=R [1]=L [2]=U [3]=D
    logic       inh;
    int         hold;
    int         er, el, eu, ed;
    int         edir;
    int         elock;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int k;

    tbl[0] = '{4'b0001, 1'b0,  20, 1, 0, 0, 0, 0, 1};
    tbl[1] = '{4'b0010, 1'b0,  20, 0, 1, 0, 0, 1, 1};
    tbl[2] = '{4'b0100, 1'b0, 100, 0, 0, 1, 0, 2, 1};
    tbl[3] = '{4'b1000, 1'b0,  20, 0, 0, 0, 1, 3, 1};
    tbl[4] = '{4'b1010, 1'b0,  20, 0, 1, 0, 0, 1, 1};
    tbl[5] = '{4'b1111, 1'b0,  20, 1, 0, 0, 0, 0, 1};
    tbl[6] = '{4'b1100, 1'b0,  20, 0, 0, 1, 0, 2, 1};
    tbl[7] = '{4'b0001, 1'b1,  20, 0, 0, 0, 0, 2, 1};
    tbl[8] = '{4'b0000, 1'b0,  20, 0, 0, 0, 0, 2, 0};

    // Reset with every button held, then the exact release-to-pulse latency.
    rst_n   = 1'b0;
    inhibit = 1'b0;
    set_raw(4'b1111);
    wait_cyc(3);
    check("rst_btn", int'({btnL, btnR, btnU, btnD}), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_dir", int'(dir_last), 0);

    rst_n = 1'b1;
    clear_counts();
    k = 0;
    while (k < 20) begin
      wait_cyc(1);
      k++;
      if (btnR === 1'b1) break;
    end
    check("rst_latency", k, 7);
    wait_cyc(10);
    check("rst_p_r", p_r, 1);
    check("rst_p_other", p_l + p_u + p_d, 0);
    check("rst_locked_after", int'(locked), 1);
    check("rst_dir_after", int'(dir_last), 0);
    release_all();

    for (int i = 0; i < 9; i++) begin
      clear_counts();
      set_raw(tbl[i].raw);
      inhibit = tbl[i].inh;
      wait_cyc(tbl[i].hold);
      check($sformatf("vec%0d_r", i), p_r, tbl[i].er);
      check($sformatf("vec%0d_l", i), p_l, tbl[i].el);
      check($sformatf("vec%0d_u", i), p_u, tbl[i].eu);
      check($sformatf("vec%0d_d", i), p_d, tbl[i].ed);
      check($sformatf("vec%0d_dir", i), int'(dir_last), tbl[i].edir);
      check($sformatf("vec%0d_locked", i), int'(locked), tbl[i].elock);
      release_all();
    end

    // Bounce: 2-cycle segments never survive the window, then a clean hold.
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      raw_l = ~raw_l;
      wait_cyc(2);
    end
    wait_cyc(6);
    check("bounce_no_pulse", p_r + p_l + p_u + p_d, 0);
    check("bounce_no_lock", int'(locked_seen), 0);
    raw_l = 1'b1;
    wait_cyc(20);
    check("bounce_p_l", p_l, 1);
    check("bounce_p_other", p_r + p_u + p_d, 0);
    check("bounce_dir", int'(dir_last), 1);
    release_all();

    // Long hold on U, then D joins while U is still down.
    clear_counts();
    raw_u = 1'b1;
    wait_cyc(100);
    check("hold_p_u", p_u, 1);
    raw_d = 1'b1;
    wait_cyc(30);
    check("hold_no_d", p_d, 0);
    check("hold_locked", int'(locked), 1);
    release_all();
    clear_counts();
    raw_d = 1'b1;
    wait_cyc(20);
    check("hold_repress_d", p_d, 1);
    check("hold_dir", int'(dir_last), 3);
    release_all();

    // Inhibit dropped while R is still held gives no late pulse.
    clear_counts();
    inhibit = 1'b1;
    raw_r   = 1'b1;
    wait_cyc(20);
    check("inh_no_pulse", p_r, 0);
    check("inh_locked", int'(locked), 1);
    inhibit = 1'b0;
    wait_cyc(20);
    check("inh_drop_no_pulse", p_r + p_l + p_u + p_d, 0);
    release_all();
    clear_counts();
    raw_r = 1'b1;
    wait_cyc(20);
    check("inh_repress_r", p_r, 1);
    check("inh_dir", int'(dir_last), 0);
    release_all();

    // A 3-cycle glitch is one short of the window.
    clear_counts();
    raw_u = 1'b1;
    wait_cyc(3);
    raw_u = 1'b0;
    wait_cyc(20);
    check("glitch_no_pulse", p_r + p_l + p_u + p_d, 0);
    check("glitch_no_lock", int'(locked_seen), 0);

    // Reset while D is held and locked: the press must be debounced again.
    raw_d = 1'b1;
    wait_cyc(20);
    rst_n = 1'b0;
    wait_cyc(1);
    check("midrst_dir", int'(dir_last), 0);
    check("midrst_locked", int'(locked), 0);
    rst_n = 1'b1;
    clear_counts();
    k = 0;
    while (k < 20) begin
      wait_cyc(1);
      k++;
      if (btnD === 1'b1) break;
    end
    check("midrst_latency", k, 7);
    wait_cyc(5);
    check("midrst_p_d", p_d, 1);
    check("midrst_dir_after", int'(dir_last), 3);
    release_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_input_conditioner.md
Name: move_input_conditioner

Overview:
Upstream stage of logic_2048. Converts four raw, asynchronous, bouncy push-buttons into clean single-cycle move pulses on btnL/btnR/btnU/btnD. Each pulse is one clean rising edge, so logic_2048 registers exactly one move per physical press. It enforces one move per press and one direction at a time, and drops presses while the game is showing a win/lose screen.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (5 ms at 100 MHz).
CNT_WIDTH, 19, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
SYNC_STAGES, 2, synchronizer flop depth per button (minimum 2).

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
raw_l  input  1  raw left button, asynchronous
raw_r  input  1  raw right button, asynchronous
raw_u  input  1  raw up button, asynchronous
raw_d  input  1  raw down button, asynchronous
inhibit  input  1  high while logic_2048 won or lost is asserted; presses are discarded
btnL  output  1  one-cycle move-left pulse to logic_2048
btnR  output  1  one-cycle move-right pulse
btnU  output  1  one-cycle move-up pulse
btnD  output  1  one-cycle move-down pulse
locked  output  1  high while waiting for all buttons to be released
dir_last  output  2  code of the last emitted direction (R=0, L=1, U=2, D=3)

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-low on rst_n; all flops are cleared on the clk edge where rst_n=0.
- Reset values: sync chains 0, debounced states 0, counters 0, FSM IDLE, btnL/R/U/D 0, locked 0, dir_last 0.
- Reset mid-press: the button must pass through the debouncer again before it can produce a pulse.
- Synchronizer: raw_x passes through SYNC_STAGES flops to give sync_x.
- Debounce, per button:
  - Counter clears whenever sync_x == stable_x.
  - Otherwise it increments each cycle.
  - When sync_x != stable_x and the counter == DEBOUNCE_CYCLES-1, stable_x toggles on the next edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- press_x = stable_x AND NOT stable_x_prev, a one-cycle internal event.
- FSM states:
  - IDLE:
    - If any stable_x=1 and inhibit=0: choose a direction by priority R>L>U>D, assert that output for exactly one cycle (registered), update dir_last, go to LOCK.
    - If any stable_x=1 and inhibit=1: go to LOCK with no pulse.
  - LOCK: locked=1; no pulses. When all stable_x=0, return to IDLE on the next edge.
- Consequences of the FSM:
  - A second button pressed while another is held produces no pulse until everything is released and pressed again.
  - Simultaneous debounced presses produce exactly one pulse, from the highest-priority button.
  - A button held across an inhibit falling edge produces no pulse.
- Latency: from a raw edge that stays stable to the output pulse is SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles (±1 for raw sampling phase).
- At most one of btnL/R/U/D is high in any cycle.
- After a pulse, all four outputs stay low for at least one cycle.
- The counter saturates logically: it never wraps, because it clears on toggle.

Decomposition:
- Shared package (game_2048_pkg):
  - direction codes DIR_R/DIR_L/DIR_U/DIR_D (2-bit);
  - FSM state encoding ST_IDLE/ST_LOCK;
  - default DEBOUNCE_CYCLES constant.
- One sub-module, debounce_bit: synchronizer plus debounce counter for one button, outputs stable and a rise strobe. It is instantiated four times.
- The top holds the priority select, the FSM and the output registers.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset: hold rst_n=0 for 3 cycles with all raw buttons high → all outputs 0 and locked=0. Release reset → exactly one btnR pulse 7±1 cycles later, then locked=1.
- Bounce: toggle raw_l 0/1 every 2 cycles for 20 cycles, then hold 1 → no pulse during the bouncing; exactly one btnL pulse, dir_last=1.
- Hold: hold raw_u for 100 cycles → exactly one btnU pulse. Press raw_d while raw_u is still held → no btnD. Release both, then press raw_d → one btnD pulse.
- Simultaneous: raw_l and raw_d rise in the same cycle → only btnL pulses, dir_last=1, locked=1 until both are released.
- Inhibit: assert inhibit=1 and press raw_r → no pulse, locked=1. Drop inhibit while raw_r is still held → still no pulse. Release and re-press → one btnR.
- Glitch: a 3-cycle raw_u pulse → no output and locked stays 0.
